// File: rtl/traffic_lights_pkg.sv
// Shared definitions for the traffic-lights controller and its command generator.
//   cmd_e : 3-bit command code carried on cmd_type_o and consumed by traffic_lights.
package traffic_lights_pkg;

  typedef enum logic [2:0] {
    CmdOn        = 3'd0,
    CmdOff       = 3'd1,
    CmdNotr      = 3'd2,
    CmdSetGreen  = 3'd3,
    CmdSetRed    = 3'd4,
    CmdSetYellow = 3'd5
  } cmd_e;

endpackage

// File: rtl/traffic_lights_cmd_gen.sv
// Command generator for the traffic-lights controller.
// Turns an accepted phase-duration configuration into the command stream
// NOTRANSITION, SET_RED, SET_YELLOW, SET_GREEN, ON, with CMD_GAP idle cycles
// between commands, and issues OFF on request.
//
// Ports:
//   clk_i        : clock
//   srst_i       : synchronous active-high reset
//   cfg_valid_i  : configuration request valid
//   cfg_ready_o  : configuration accepted when valid && ready
//   cfg_red_i    : red phase duration (ms)
//   cfg_yellow_i : yellow phase duration (ms)
//   cfg_green_i  : green phase duration (ms)
//   off_req_i    : request to switch the lights off
//   cmd_type_o   : command code (cmd_e), 0 when cmd_valid_o is low
//   cmd_valid_o  : one-cycle command strobe
//   cmd_data_o   : command payload, 0 when cmd_valid_o is low
//   busy_o       : sequence in progress
//   err_o        : one-cycle pulse on a rejected configuration
module traffic_lights_cmd_gen
  import traffic_lights_pkg::*;
#(
  parameter int unsigned CMD_GAP = 0,
  parameter int unsigned DATA_W  = 16
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [DATA_W-1:0] cfg_red_i,
  input  logic [DATA_W-1:0] cfg_yellow_i,
  input  logic [DATA_W-1:0] cfg_green_i,
  input  logic              off_req_i,
  output logic [2:0]        cmd_type_o,
  output logic              cmd_valid_o,
  output logic [DATA_W-1:0] cmd_data_o,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    StIdle, StNotr, StRed, StYel, StGrn, StOn, StOff, StGap
  } state_e;

  // Gap counter is loaded with CMD_GAP-1 and counts down to 0 inside StGap.
  localparam logic [3:0] GapInit = (CMD_GAP == 0) ? 4'd0 : 4'(CMD_GAP - 1);

  state_e            state_q, state_d;
  state_e            next_q, next_d;
  state_e            tgt;
  logic [3:0]        gap_q, gap_d;
  logic              pend_q, pend_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] red_q, red_d;
  logic [DATA_W-1:0] yel_q, yel_d;
  logic [DATA_W-1:0] grn_q, grn_d;
  logic              accept;
  logic              leave;
  logic              off_now;

  // Off wins over configuration, and nothing is accepted during reset.
  assign cfg_ready_o = (state_q == StIdle) && !off_req_i && !srst_i;
  assign accept      = cfg_valid_i && cfg_ready_o;
  assign off_now     = pend_q || off_req_i;

  always_comb begin
    state_d = state_q;
    next_d  = next_q;
    gap_d   = gap_q;
    pend_d  = pend_q;
    err_d   = 1'b0;
    red_d   = red_q;
    yel_d   = yel_q;
    grn_d   = grn_q;
    tgt     = StIdle;
    leave   = 1'b0;

    case (state_q)
      StIdle: begin
        if (off_req_i) begin
          state_d = StOff;
        end else if (accept) begin
          if (cfg_red_i == '0 || cfg_yellow_i == '0 || cfg_green_i == '0) begin
            err_d = 1'b1;
          end else begin
            red_d   = cfg_red_i;
            yel_d   = cfg_yellow_i;
            grn_d   = cfg_green_i;
            state_d = StNotr;
          end
        end
      end
      StNotr: begin leave = 1'b1; tgt = StRed;  end
      StRed:  begin leave = 1'b1; tgt = StYel;  end
      StYel:  begin leave = 1'b1; tgt = StGrn;  end
      StGrn:  begin leave = 1'b1; tgt = StOn;   end
      StOn:   begin leave = 1'b1; tgt = StIdle; end
      StOff: begin
        pend_d  = 1'b0;
        state_d = StIdle;
      end
      StGap: begin
        pend_d = off_now;
        if (gap_q == 4'd0) begin
          state_d = off_now ? StOff : next_q;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Leaving a command state: a pending off replaces the rest of the sequence.
    if (leave) begin
      pend_d = off_now;
      if (off_now) begin
        tgt = StOff;
      end
      if (CMD_GAP == 0 || tgt == StIdle) begin
        state_d = tgt;
      end else begin
        state_d = StGap;
        next_d  = tgt;
        gap_d   = GapInit;
      end
    end
  end

  always_comb begin
    cmd_valid_o = 1'b0;
    cmd_type_o  = 3'd0;
    cmd_data_o  = '0;
    if (!srst_i) begin
      case (state_q)
        StNotr: begin cmd_valid_o = 1'b1; cmd_type_o = CmdNotr; end
        StRed: begin
          cmd_valid_o = 1'b1;
          cmd_type_o  = CmdSetRed;
          cmd_data_o  = red_q;
        end
        StYel: begin
          cmd_valid_o = 1'b1;
          cmd_type_o  = CmdSetYellow;
          cmd_data_o  = yel_q;
        end
        StGrn: begin
          cmd_valid_o = 1'b1;
          cmd_type_o  = CmdSetGreen;
          cmd_data_o  = grn_q;
        end
        StOn:  begin cmd_valid_o = 1'b1; cmd_type_o = CmdOn;  end
        StOff: begin cmd_valid_o = 1'b1; cmd_type_o = CmdOff; end
        default: ;
      endcase
    end
  end

  assign busy_o = (state_q != StIdle) && !srst_i;
  assign err_o  = err_q && !srst_i;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= StIdle;
      next_q  <= StIdle;
      gap_q   <= 4'd0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      red_q   <= '0;
      yel_q   <= '0;
      grn_q   <= '0;
    end else begin
      state_q <= state_d;
      next_q  <= next_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      red_q   <= red_d;
      yel_q   <= yel_d;
      grn_q   <= grn_d;
    end
  end

endmodule

// File: doc/traffic_lights_cmd_gen.md
TRAFFIC_LIGHTS_CMD_GEN -- requirements
Module: traffic_lights_cmd_gen

Interface
REQ-001 Parameter CMD_GAP, default 0: idle cycles inserted between consecutive commands (0..15).
REQ-002 Parameter DATA_W, default 16: width of the phase-duration fields and of cmd_data_o.
REQ-003 clk_i  input  1  single clock for all logic.
REQ-004 srst_i  input  1  synchronous, active-high reset.
REQ-005 cfg_valid_i  input  1  configuration request valid.
REQ-006 cfg_ready_o  output  1  configuration request accepted when cfg_valid_i && cfg_ready_o.
REQ-007 cfg_red_i  input  DATA_W  red phase duration, ms.
REQ-008 cfg_yellow_i  input  DATA_W  yellow phase duration, ms.
REQ-009 cfg_green_i  input  DATA_W  green phase duration, ms.
REQ-010 off_req_i  input  1  request to switch the lights off.
REQ-011 cmd_type_o  output  3  command code: 0 ON, 1 OFF, 2 NOTRANSITION, 3 SET_GREEN, 4 SET_RED, 5 SET_YELLOW.
REQ-012 cmd_valid_o  output  1  one-cycle command strobe.
REQ-013 cmd_data_o  output  DATA_W  command payload.
REQ-014 busy_o  output  1  high while a sequence is in progress.
REQ-015 err_o  output  1  one-cycle pulse on a rejected configuration.

Function
REQ-016 The FSM SHALL have the states IDLE, S_NOTR, S_RED, S_YEL, S_GRN, S_ON, S_OFF and GAP.
REQ-017 cfg_ready_o SHALL be high only in IDLE with off_req_i low.
REQ-018 On accept, the three durations SHALL be latched and later input changes SHALL be ignored.
REQ-019 An accepted configuration with any field equal to 0 SHALL produce an err_o pulse on the next cycle, emit no commands, and leave the FSM in IDLE.
REQ-020 A valid configuration accepted at cycle N SHALL emit cmd_valid_o in cycle N+1 with type 2, then types 4, 5, 3, 0 in that order; each command SHALL be separated from the next by exactly CMD_GAP idle cycles.
REQ-021 cmd_data_o SHALL carry the latched red, yellow or green value for types 4, 5 and 3, and SHALL be 0 for types 0, 1 and 2.
REQ-022 cmd_type_o and cmd_data_o SHALL be 0 whenever cmd_valid_o is low.
REQ-023 busy_o SHALL be high from cycle N+1 through the cycle that emits type 0; the FSM SHALL return to IDLE on the following cycle.
REQ-024 off_req_i high in IDLE SHALL emit type 1 with data 0 on the next cycle, then return to IDLE.
REQ-025 off_req_i high during a sequence SHALL be latched; the command in progress completes, remaining commands SHALL be dropped, type 1 SHALL be emitted after the normal gap, then the FSM returns to IDLE.
REQ-026 When cfg_valid_i and off_req_i are both high in IDLE, the off request SHALL win and the configuration SHALL NOT be accepted.
REQ-027 The gap counter SHALL be 4 bits wide; CMD_GAP=0 SHALL produce back-to-back commands with no GAP state visited.

Reset
REQ-028 srst_i SHALL force the FSM to IDLE and drive cmd_valid_o=0, cmd_type_o=0, cmd_data_o=0, busy_o=0, err_o=0.
REQ-029 srst_i SHALL also set cfg_ready_o=0 during the reset cycle, clear the latched fields and clear the pending-off flag.
REQ-030 Reset asserted mid-sequence SHALL abort the sequence with no further commands emitted.

Structure
REQ-031 The package traffic_lights_pkg SHALL hold the command-code enum (ON..SET_YELLOW, 3 bits) shared with traffic_lights.
REQ-032 The FSM state typedef SHALL remain local to this module.
REQ-033 No sub-module is required; the design SHALL be a single module of roughly 150-250 lines.

Verification
REQ-034 Config red=5, yellow=3, green=7 with CMD_GAP=0: cmd_valid_o high for 5 consecutive cycles starting N+1, carrying (2,0), (4,5), (5,3), (3,7), (0,0); busy_o high for 5 cycles.
REQ-035 The same config with CMD_GAP=2: commands at N+1, N+4, N+7, N+10, N+13.
REQ-036 Config with green=0: err_o pulse at N+1, no cmd_valid_o, cfg_ready_o high again at N+1.
REQ-037 off_req_i pulsed in the cycle of the SET_RED command (CMD_GAP=0): output sequence (2,0), (4,r), (1,0), then IDLE.
REQ-038 cfg_valid_i and off_req_i both high in IDLE: only (1,0) emitted; cfg not accepted.
REQ-039 srst_i asserted on the SET_YELLOW cycle: no commands after reset, all outputs 0, cfg_ready_o high the cycle after reset deasserts.
